// File: rtl/rf_write_arbiter_if.sv
// One register-file write requester: a valid/ready beat carrying destination,
// data and a lock flag that keeps the port after this beat.
interface rf_write_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
    logic          ready;

    modport master (output valid, output addr, output data, output lock, input ready);
    modport slave  (input valid, input addr, input data, input lock, output ready);
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter with lock for the register file's single write port.
// The granted beat is registered one cycle before it reaches the file.
module rf_write_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                hold,
    rf_write_arbiter_if.slave   req0,
    rf_write_arbiter_if.slave   req1,
    rf_write_arbiter_if.slave   req2,
    output logic                rf_lde,
    output logic [AW-1:0]       rf_ddata,
    output logic [DW-1:0]       rf_datain,
    output logic                locked,
    output logic [1:0]          owner,
    output logic [15:0]         wr_count
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    owner_q, owner_d;
    logic          rf_lde_q;
    logic [AW-1:0] rf_ddata_q;
    logic [DW-1:0] rf_datain_q;
    logic [15:0]   wr_count_q;

    logic [2:0]    vld;
    logic [2:0]    lck;
    logic [AW-1:0] addr_a [3];
    logic [DW-1:0] data_a [3];
    logic [2:0]    gnt;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic          found;
    logic          accept;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign vld       = {req2.valid, req1.valid, req0.valid};
    assign lck       = {req2.lock, req1.lock, req0.lock};
    assign addr_a[0] = req0.addr;
    assign addr_a[1] = req1.addr;
    assign addr_a[2] = req2.addr;
    assign data_a[0] = req0.data;
    assign data_a[1] = req1.data;
    assign data_a[2] = req2.data;

    // While locked only the owner is eligible, even if it is not presenting a beat.
    always_comb begin
        gnt     = '0;
        gnt_idx = 2'd0;
        cand    = ptr_q;
        found   = 1'b0;
        if (!hold) begin
            if (state_q == ST_LOCKED) begin
                if (vld[owner_q]) begin
                    found   = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!found && vld[cand]) begin
                        found   = 1'b1;
                        gnt_idx = cand;
                    end
                    cand = inc3(cand);
                end
            end
        end
        if (found) gnt[gnt_idx] = 1'b1;
    end

    assign accept     = found;
    assign req0.ready = gnt[0];
    assign req1.ready = gnt[1];
    assign req2.ready = gnt[2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (lck[gnt_idx]) begin
                    state_d = ST_LOCKED;
                    owner_d = gnt_idx;
                end else begin
                    ptr_d = inc3(gnt_idx);
                end
            end else if (!lck[gnt_idx]) begin
                state_d = ST_IDLE;
                ptr_d   = inc3(owner_q);
                owner_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            rf_lde_q    <= 1'b0;
            rf_ddata_q  <= '0;
            rf_datain_q <= '0;
            wr_count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rf_lde_q <= accept;
            if (accept) begin
                rf_ddata_q  <= addr_a[gnt_idx];
                rf_datain_q <= data_a[gnt_idx];
                if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rf_lde    = rf_lde_q;
    assign rf_ddata  = rf_ddata_q;
    assign rf_datain = rf_datain_q;
    assign locked    = (state_q == ST_LOCKED);
    assign owner     = owner_q;
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a per-cycle reference model plus
// hand-computed expectations for reset, single write, rotation, lock, hold, saturation.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        hold = 1'b0;
    logic        rf_lde;
    logic [3:0]  rf_ddata;
    logic [31:0] rf_datain;
    logic        locked;
    logic [1:0]  owner;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter_if #(.DW(32), .AW(4)) r0 ();
    rf_write_arbiter_if #(.DW(32), .AW(4)) r1 ();
    rf_write_arbiter_if #(.DW(32), .AW(4)) r2 ();

    rf_write_arbiter #(.DW(32), .AW(4)) dut (
        .clk(clk), .clr(clr), .hold(hold),
        .req0(r0.slave), .req1(r1.slave), .req2(r2.slave),
        .rf_lde(rf_lde), .rf_ddata(rf_ddata), .rf_datain(rf_datain),
        .locked(locked), .owner(owner), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input int n, input bit v, input logic [3:0] a, input logic [31:0] d, input bit l);
        case (n)
            0: begin r0.valid = v; r0.addr = a; r0.data = d; r0.lock = l; end
            1: begin r1.valid = v; r1.addr = a; r1.data = d; r1.lock = l; end
            default: begin r2.valid = v; r2.addr = a; r2.data = d; r2.lock = l; end
        endcase
    endtask

    task automatic idle_all();
        for (int n = 0; n < 3; n++) drv(n, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: arbitration rules applied to what the requesters present.
    int          m_ptr = 0, m_owner = 0, m_cnt = 0;
    bit          m_locked = 0, m_lde = 0;
    logic [3:0]  m_dd = '0;
    logic [31:0] m_di = '0;

    always @(negedge clk) begin
        bit          vv[3], lk[3];
        logic [3:0]  aa[3];
        logic [31:0] dd[3];
        int          g;
        vv[0] = r0.valid; vv[1] = r1.valid; vv[2] = r2.valid;
        lk[0] = r0.lock;  lk[1] = r1.lock;  lk[2] = r2.lock;
        aa[0] = r0.addr;  aa[1] = r1.addr;  aa[2] = r2.addr;
        dd[0] = r0.data;  dd[1] = r1.data;  dd[2] = r2.data;
        if (!clr) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_lde = 0; m_dd = '0; m_di = '0;
        end
        g = -1;
        if (!hold) begin
            if (m_locked) begin
                if (vv[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < 3; k++)
                    if (g < 0 && vv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        chk("ready0", r0.ready, g == 0);
        chk("ready1", r1.ready, g == 1);
        chk("ready2", r2.ready, g == 2);
        chk("rf_lde", rf_lde, m_lde);
        chk("rf_ddata", rf_ddata, m_dd);
        chk("rf_datain", rf_datain, m_di);
        chk("locked", locked, m_locked);
        chk("owner", owner, m_owner);
        chk("wr_count", wr_count, m_cnt);
        if (clr) begin
            m_lde = (g >= 0);
            if (g >= 0) begin
                m_dd = aa[g];
                m_di = dd[g];
                if (m_cnt < 65535) m_cnt++;
                if (m_locked) begin
                    if (!lk[g]) begin
                        m_locked = 0;
                        m_ptr = (m_owner + 1) % 3;
                        m_owner = 0;
                    end
                end else if (lk[g]) begin
                    m_locked = 1;
                    m_owner = g;
                end else begin
                    m_ptr = (g + 1) % 3;
                end
            end
        end
    end

    initial begin
        int order[6];
        order = '{0, 1, 2, 0, 1, 2};
        // Reset with every requester valid
        drv(0, 1, 4'h1, 32'h11, 0);
        drv(1, 1, 4'h2, 32'h22, 0);
        drv(2, 1, 4'h3, 32'h33, 0);
        repeat (3) step();
        chk("rst_lde", rf_lde, 0);
        chk("rst_ddata", rf_ddata, 0);
        chk("rst_cnt", wr_count, 0);
        clr = 1'b1;
        #1;
        chk("first_grant0", r0.ready, 1);
        chk("first_grant1", r1.ready, 0);
        step();
        chk("first_ddata", rf_ddata, 4'h1);

        // Single write from req1 (fresh reset)
        idle_all();
        clr = 1'b0;
        step();
        clr = 1'b1;
        drv(1, 1, 4'hA, 32'h000A0000, 0);
        #1;
        chk("single_ready", r1.ready, 1);
        step();
        idle_all();
        chk("single_lde", rf_lde, 1);
        chk("single_ddata", rf_ddata, 4'hA);
        chk("single_datain", rf_datain, 32'h000A0000);
        chk("single_cnt", wr_count, 1);

        // Round-robin from ptr 0 (fresh reset)
        clr = 1'b0;
        step();
        clr = 1'b1;
        drv(0, 1, 4'h1, 32'h100, 0);
        drv(1, 1, 4'h2, 32'h200, 0);
        drv(2, 1, 4'h3, 32'h300, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", {r2.ready, r1.ready, r0.ready}, 3'b001 << order[i]);
            step();
            chk("rr_lde", rf_lde, 1);
            chk("rr_addr", rf_ddata, order[i] + 1);
        end
        idle_all();
        chk("rr_cnt", wr_count, 6);

        // Move ptr to 2 with a lone req1 beat, then req2 locked transfer
        drv(1, 1, 4'h2, 32'h200, 0);
        step();
        drv(0, 1, 4'h1, 32'h1000, 0);
        drv(1, 1, 4'h2, 32'h2000, 0);
        drv(2, 1, 4'h4, 32'h4444, 1);
        #1;
        chk("lock_b1", {r2.ready, r1.ready, r0.ready}, 3'b100);
        step();
        chk("lock_locked", locked, 1);
        chk("lock_owner", owner, 2);
        drv(2, 0, 4'h4, 32'h0, 1);
        #1;
        chk("lock_gap_ready", {r2.ready, r1.ready, r0.ready}, 3'b000);
        step();
        chk("lock_gap_lde", rf_lde, 0);
        drv(2, 1, 4'h5, 32'h5555, 1);
        #1;
        chk("lock_b2", {r2.ready, r1.ready, r0.ready}, 3'b100);
        step();
        drv(2, 1, 4'hF, 32'hFFFF, 0);
        #1;
        chk("lock_b3", {r2.ready, r1.ready, r0.ready}, 3'b100);
        step();
        chk("lock_release", locked, 0);
        chk("lock_r15", rf_ddata, 4'hF);
        drv(2, 1, 4'h3, 32'h3000, 0);
        #1;
        chk("after_release", {r2.ready, r1.ready, r0.ready}, 3'b001);

        // Hold during contention: ptr is 1 after req0's beat
        step();
        hold = 1'b1;
        #1;
        chk("hold_ready", {r2.ready, r1.ready, r0.ready}, 3'b000);
        step();
        step();
        chk("hold_lde", rf_lde, 0);
        hold = 1'b0;
        #1;
        chk("hold_resume", {r2.ready, r1.ready, r0.ready}, 3'b010);
        step();
        idle_all();

        // Reset in the middle of a locked transfer
        drv(1, 1, 4'h7, 32'h7777, 1);
        step();
        step();
        chk("midlock_locked", locked, 1);
        clr = 1'b0;
        #1;
        chk("midlock_rst_locked", locked, 0);
        chk("midlock_rst_lde", rf_lde, 0);
        idle_all();
        step();
        step();
        clr = 1'b1;

        // Saturation of wr_count
        clr = 1'b0;
        step();
        clr = 1'b1;
        drv(0, 1, 4'h9, 32'h9, 0);
        repeat (65534) step();
        idle_all();
        step();
        chk("sat_fffe", wr_count, 16'hFFFE);
        drv(0, 1, 4'h9, 32'h9, 0);
        repeat (2) step();
        idle_all();
        step();
        chk("sat_ffff", wr_count, 16'hFFFF);
        drv(0, 1, 4'h9, 32'h9, 0);
        step();
        idle_all();
        step();
        chk("sat_hold", wr_count, 16'hFFFF);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (load enable, 4-bit destination select, 32-bit write data) among three independent writers: ALU writeback, load writeback and PC/link update. Round-robin arbitration, valid/ready handshake per requester, and a lock mechanism that keeps the port with one owner for multi-register transfers (block loads). Sits between the pipeline writeback logic and the 16 x 32 register file, and registers the granted write one cycle before it reaches the file.

## Interface
- DW, 32, write data width
- AW, 4, register select width (16 registers, R15 = PC)
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- hold  in  1  global stall; no grants while high
- reqN_valid  in  1  requester N (N = 0,1,2) has a write pending
- reqN_addr  in  AW  destination register of requester N
- reqN_data  in  DW  write data of requester N
- reqN_lock  in  1  requester N wants to keep the port after this beat
- reqN_ready  out  1  requester N's beat is accepted this cycle (combinational)
- rf_lde  out  1  register file load enable (registered)
- rf_ddata  out  AW  register file destination select (registered)
- rf_datain  out  DW  register file write data (registered)
- locked  out  1  arbiter is in LOCKED state
- owner  out  2  owning requester while locked; 0 otherwise
- wr_count  out  16  number of accepted writes since reset, saturating at 16'hFFFF

## Operation
- Accept on requester N = reqN_valid && reqN_ready. At most one reqN_ready high per cycle.
- Priority pointer ptr (0..2), reset 0. Order of preference: ptr, ptr+1, ptr+2 (mod 3).
- States:
  - IDLE: grant the highest-priority valid requester if hold = 0.
    - If the accepted beat has lock = 0: stay IDLE, ptr <= (N+1) mod 3.
    - If lock = 1: go to LOCKED, owner <= N. ptr is unchanged.
  - LOCKED: only the owner can be granted. Other requesters get ready = 0 even when the owner's valid is low.
    - Owner beat accepted with lock = 1: stay LOCKED.
    - Owner beat accepted with lock = 0: go to IDLE, ptr <= (owner+1) mod 3, owner <= 0.
    - Owner valid low: no grant, remain LOCKED (no timeout).
- hold = 1: all ready = 0. State, ptr and owner are unchanged; rf_lde = 0 on the next edge.
- Output stage, updated every edge:
  - rf_lde <= accept-any.
  - On accept: rf_ddata <= addr, rf_datain <= data of the accepted requester.
  - Without accept: rf_ddata and rf_datain hold their previous values.
- wr_count increments on every accept and saturates at 16'hFFFF (no wrap).
- Same-register writes from different requesters are serialized in grant order. The last accepted beat wins in the file. No merging.
- reqN_ready may depend on the valid inputs of all requesters. A requester's valid must not depend on its own ready.

## Timing
- Reset (clr low, asynchronous), all outputs and state:
  - rf_lde 0, rf_ddata 0, rf_datain 0.
  - ptr 0, state IDLE, locked 0, owner 0, wr_count 0.
- Reset asserted mid-lock aborts the transfer: IDLE next, no further rf_lde pulses.
- Latency: a beat accepted in cycle t appears on rf_lde/rf_ddata/rf_datain during cycle t+1. The register file captures it at the end of t+1.
- Throughput: one write per cycle while any eligible requester is valid.
- locked and owner are registered. They change on the edge that accepts the first locked beat or the releasing beat.
- Fairness: under continuous three-way contention without lock, grants rotate 0,1,2,0,… and each requester waits at most 2 beats.

## Test plan
- Reset:
  - Drive all valids high with clr low, then release clr.
  - rf_lde stays 0 while clr is low.
  - First grant goes to req0 (ptr = 0).
  - rf_ddata/rf_datain = 0 until the first accept.
- Single write:
  - Stimulus: req1 valid, addr 4'hA, data 32'h000A0000, lock 0.
  - Response: req1_ready high the same cycle; next cycle rf_lde = 1, rf_ddata = 4'hA, rf_datain = 32'h000A0000; wr_count = 1.
- Round-robin:
  - Stimulus: all three valid for 6 cycles with distinct addrs 1/2/3 and lock 0.
  - Response: grant order 0,1,2,0,1,2; rf_lde high for 6 consecutive cycles; wr_count = 6.
- Lock:
  - Stimulus: req2 issues 3 beats (R4, R5, R15) with lock 1,1,0; req0 and req1 are valid throughout; req2 valid drops for one cycle between beats 1 and 2.
  - Required:
    - req0/req1 ready stay 0 until req2's third beat is accepted.
    - rf_lde shows a 1-cycle gap during the dropped-valid cycle.
    - After release, ptr = 0 and req0 is granted next.
- Hold:
  - Stimulus: assert hold for 2 cycles during contention.
  - Response: ready all 0 and rf_lde 0 one cycle later; the grant sequence resumes at the same ptr.
- Reset mid-lock and saturation:
  - Pull clr low while locked: locked = 0 and rf_lde = 0 immediately.
  - Separately, preload wr_count to 16'hFFFE by 65534 accepts, then accept 2 more: wr_count = 16'hFFFF.
